// File: rtl/rsa_avm_wrapper_p.sv
// Avalon-MM master that polls a UART register map, gathers key (n,d) and cipher bytes, runs an external modexp core
// and writes the result bytes back to TX; every bus request is held unchanged while avm_waitrequest is high.
module rsa_avm_wrapper_p #(
   parameter int KEY_BITS    = 256,
   parameter int OUT_SKIP    = 1,
   parameter int ADDR_W      = 5,
   parameter int RX_BASE     = 0,
   parameter int TX_BASE     = 4,
   parameter int STATUS_BASE = 8,
   parameter int RX_OK_BIT   = 7,
   parameter int TX_OK_BIT   = 6,
   parameter int CNT_W       = 16
) (
   input  logic                avm_clk,
   input  logic                avm_rst,
   output logic [ADDR_W-1:0]   avm_address,
   output logic                avm_read,
   input  logic [31:0]         avm_readdata,
   output logic                avm_write,
   output logic [31:0]         avm_writedata,
   input  logic                avm_waitrequest,
   output logic                o_core_start,
   output logic [KEY_BITS-1:0] o_core_a,
   output logic [KEY_BITS-1:0] o_core_d,
   output logic [KEY_BITS-1:0] o_core_n,
   input  logic [KEY_BITS-1:0] i_core_result,
   input  logic                i_core_finished,
   input  logic                i_key_reload,
   output logic                o_busy,
   output logic [CNT_W-1:0]    o_block_count
);

   localparam int KB       = KEY_BITS / 8;
   localparam int TX_BYTES = KB - OUT_SKIP;
   localparam int CW       = $clog2(2 * KB) + 1;

   localparam logic [CW-1:0]     KEY_LAST  = CW'(2 * KB - 1);
   localparam logic [CW-1:0]     DATA_LAST = CW'(KB - 1);
   localparam logic [CW-1:0]     SEND_LAST = CW'(TX_BYTES - 1);
   localparam logic [ADDR_W-1:0] A_RX      = ADDR_W'(RX_BASE);
   localparam logic [ADDR_W-1:0] A_TX      = ADDR_W'(TX_BASE);
   localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(STATUS_BASE);

   localparam logic [2:0] S_QUERY_RX  = 3'd0;
   localparam logic [2:0] S_GET_KEY   = 3'd1;
   localparam logic [2:0] S_GET_DATA  = 3'd2;
   localparam logic [2:0] S_WAIT_CORE = 3'd3;
   localparam logic [2:0] S_QUERY_TX  = 3'd4;
   localparam logic [2:0] S_SEND      = 3'd5;

   logic [2:0]          state;
   logic [2:0]          ret_state;
   logic [CW-1:0]       cnt;
   logic                reload_q;
   logic [KEY_BITS-1:0] n_q;
   logic [KEY_BITS-1:0] d_q;
   logic [KEY_BITS-1:0] a_q;
   logic [KEY_BITS-1:0] result_q;
   logic [CW-1:0]       tx_idx;
   logic [7:0]          tx_byte;
   logic [7:0]          rx_byte;
   logic                rd_done;
   logic                wr_done;
   logic                unused_rd;

   assign rd_done   = avm_read & ~avm_waitrequest;
   assign wr_done   = avm_write & ~avm_waitrequest;
   assign rx_byte   = avm_readdata[7:0];
   assign unused_rd = ^avm_readdata;

   assign o_core_a = a_q;
   assign o_core_d = d_q;
   assign o_core_n = n_q;
   assign o_busy   = (state == S_WAIT_CORE);

   // Bytes go out most-significant first, skipping the top OUT_SKIP bytes of the result.
   assign tx_idx = SEND_LAST - cnt;
   always_comb begin
      tx_byte = '0;
      for (int i = 0; i < KB; i++) begin
         if (tx_idx == CW'(i)) tx_byte = result_q[8*i +: 8];
      end
   end

   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         state         <= S_QUERY_RX;
         ret_state     <= S_GET_KEY;
         avm_read      <= 1'b0;
         avm_write     <= 1'b0;
         avm_address   <= A_STATUS;
         avm_writedata <= '0;
         n_q           <= '0;
         d_q           <= '0;
         a_q           <= '0;
         result_q      <= '0;
         cnt           <= '0;
         reload_q      <= 1'b0;
         o_core_start  <= 1'b0;
         o_block_count <= '0;
      end else begin
         o_core_start <= 1'b0;
         if (i_key_reload) reload_q <= 1'b1;

         case (state)
            S_QUERY_RX: begin
               if (!avm_read) begin
                  avm_read    <= 1'b1;
                  avm_address <= A_STATUS;
               end else if (rd_done && avm_readdata[RX_OK_BIT]) begin
                  avm_address <= A_RX;
                  state       <= ret_state;
               end
            end

            S_GET_KEY: begin
               if (rd_done) begin
                  {n_q, d_q} <= {n_q[KEY_BITS-9:0], d_q, rx_byte};
                  if (cnt == KEY_LAST) begin
                     ret_state <= S_GET_DATA;
                     cnt       <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
                  avm_address <= A_STATUS;
                  state       <= S_QUERY_RX;
               end
            end

            S_GET_DATA: begin
               if (rd_done) begin
                  a_q <= {a_q[KEY_BITS-9:0], rx_byte};
                  if (cnt == DATA_LAST) begin
                     cnt          <= '0;
                     avm_read     <= 1'b0;
                     o_core_start <= 1'b1;
                     state        <= S_WAIT_CORE;
                  end else begin
                     cnt         <= cnt + CW'(1);
                     avm_address <= A_STATUS;
                     state       <= S_QUERY_RX;
                  end
               end
            end

            // The core may still show a stale finished flag while the start pulse is out.
            S_WAIT_CORE: begin
               if (i_core_finished && !o_core_start) begin
                  result_q    <= i_core_result;
                  avm_read    <= 1'b1;
                  avm_address <= A_STATUS;
                  state       <= S_QUERY_TX;
               end
            end

            S_QUERY_TX: begin
               if (rd_done && avm_readdata[TX_OK_BIT]) begin
                  avm_read      <= 1'b0;
                  avm_write     <= 1'b1;
                  avm_address   <= A_TX;
                  avm_writedata <= {24'b0, tx_byte};
                  state         <= S_SEND;
               end
            end

            S_SEND: begin
               if (wr_done) begin
                  avm_write   <= 1'b0;
                  avm_read    <= 1'b1;
                  avm_address <= A_STATUS;
                  if (cnt == SEND_LAST) begin
                     o_block_count <= o_block_count + CNT_W'(1);
                     cnt           <= '0;
                     a_q           <= '0;
                     ret_state     <= reload_q ? S_GET_KEY : S_GET_DATA;
                     reload_q      <= i_key_reload;
                     state         <= S_QUERY_RX;
                  end else begin
                     cnt   <= cnt + CW'(1);
                     state <= S_QUERY_TX;
                  end
               end
            end

            default: begin
               avm_read  <= 1'b0;
               avm_write <= 1'b0;
               state     <= S_QUERY_RX;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_avm_wrapper_p.sv
// Bench for rsa_avm_wrapper_p: UART slave + modexp core models, byte-level scoreboard and directed scenarios.
module tb_rsa_avm_wrapper_p;

   localparam int KEY_BITS = 32;
   localparam int OUT_SKIP = 1;
   localparam int KB       = KEY_BITS / 8;
   localparam int TXB      = KB - OUT_SKIP;
   localparam int CNT_W    = 2;
   localparam int A_RX     = 0;
   localparam int A_TX     = 4;
   localparam int A_STAT   = 8;

   logic                avm_clk;
   logic                avm_rst;
   logic [4:0]          avm_address;
   logic                avm_read;
   logic [31:0]         avm_readdata;
   logic                avm_write;
   logic [31:0]         avm_writedata;
   logic                avm_waitrequest;
   logic                o_core_start;
   logic [KEY_BITS-1:0] o_core_a;
   logic [KEY_BITS-1:0] o_core_d;
   logic [KEY_BITS-1:0] o_core_n;
   logic [KEY_BITS-1:0] i_core_result;
   logic                i_core_finished;
   logic                i_key_reload;
   logic                o_busy;
   logic [CNT_W-1:0]    o_block_count;

   rsa_avm_wrapper_p #(.KEY_BITS(KEY_BITS), .OUT_SKIP(OUT_SKIP), .CNT_W(CNT_W)) dut (
      .avm_clk(avm_clk), .avm_rst(avm_rst), .avm_address(avm_address), .avm_read(avm_read),
      .avm_readdata(avm_readdata), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_waitrequest(avm_waitrequest), .o_core_start(o_core_start), .o_core_a(o_core_a),
      .o_core_d(o_core_d), .o_core_n(o_core_n), .i_core_result(i_core_result),
      .i_core_finished(i_core_finished), .i_key_reload(i_key_reload), .o_busy(o_busy),
      .o_block_count(o_block_count)
   );

   initial avm_clk = 1'b0;
   always #5 avm_clk = ~avm_clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]       rx_q[$];
   logic [7:0]       exp_tx[$];
   logic [7:0]       tx_log[$];
   logic [95:0]      exp_ops[$];
   logic [CNT_W-1:0] exp_block_count = '0;
   int               tx_in_block = 0;
   int               max_stall = 0;
   int               rx_deny = 0;
   int               tx_deny = 0;
   int               n_starts = 0;
   logic [31:0]      cur_n = '0;
   logic [31:0]      cur_d = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] modexp(input logic [31:0] a, input logic [31:0] d, input logic [31:0] n);
      longint unsigned r, b, nn;
      nn = 64'(n);
      r  = 1 % nn;
      b  = 64'(a) % nn;
      for (int i = 0; i < 32; i++) begin
         if (d[i]) r = (r * b) % nn;
         b = (b * b) % nn;
      end
      return r[31:0];
   endfunction

   task automatic push_word(input logic [31:0] w);
      for (int j = KB - 1; j >= 0; j--) rx_q.push_back(w[8*j +: 8]);
   endtask

   task automatic send_key(input logic [31:0] n, input logic [31:0] d);
      push_word(n);
      push_word(d);
      cur_n = n;
      cur_d = d;
   endtask

   task automatic send_block(input logic [31:0] a);
      logic [31:0] r;
      push_word(a);
      r = modexp(a, cur_d, cur_n);
      for (int j = TXB - 1; j >= 0; j--) exp_tx.push_back(r[8*j +: 8]);
      exp_ops.push_back({a, cur_d, cur_n});
   endtask

   // Bus slave + per-cycle compare against the scoreboard.
   initial begin
      logic        pending, prev_stalled, rx_allowed, tx_allowed, rx_ok, tx_ok;
      int          stall_left;
      logic [4:0]  p_addr;
      logic        p_rd, p_wr;
      logic [31:0] p_wd, rd;
      logic [7:0]  exp_b;
      pending = 0; prev_stalled = 0; rx_allowed = 0; tx_allowed = 0; stall_left = 0;
      p_addr = '0; p_rd = 0; p_wr = 0; p_wd = '0;
      avm_waitrequest = 1'b0;
      avm_readdata    = '0;
      forever begin
         @(negedge avm_clk);
         if (avm_rst) begin
            pending = 0; prev_stalled = 0; rx_allowed = 0; tx_allowed = 0;
            avm_waitrequest = 1'b0;
            continue;
         end
         check("block_count", 64'(o_block_count), 64'(exp_block_count));
         check("rd_wr_exclusive", 64'(avm_read & avm_write), 64'd0);
         if (prev_stalled) begin
            check("stall_addr", 64'(avm_address), 64'(p_addr));
            check("stall_read", 64'(avm_read), 64'(p_rd));
            check("stall_write", 64'(avm_write), 64'(p_wr));
            if (p_wr) check("stall_wdata", 64'(avm_writedata), 64'(p_wd));
         end
         prev_stalled = 0;
         if (avm_read || avm_write) begin
            if (!pending) begin
               pending    = 1;
               stall_left = $urandom_range(max_stall, 0);
            end
            if (stall_left > 0) begin
               stall_left--;
               avm_waitrequest = 1'b1;
               avm_readdata    = $urandom;
               prev_stalled    = 1;
               p_addr = avm_address; p_rd = avm_read; p_wr = avm_write; p_wd = avm_writedata;
            end else begin
               avm_waitrequest = 1'b0;
               pending         = 0;
               rd              = $urandom;
               if (avm_read) begin
                  if (avm_address == 5'(A_STAT)) begin
                     rx_ok = (rx_q.size() > 0) && (rx_deny == 0);
                     if (rx_q.size() > 0 && rx_deny > 0) rx_deny--;
                     tx_ok = (tx_deny == 0);
                     if (rx_q.size() == 0 && tx_deny > 0) tx_deny--;
                     rd[7] = rx_ok;
                     rd[6] = tx_ok;
                     rx_allowed = rx_ok;
                     tx_allowed = tx_ok;
                  end else if (avm_address == 5'(A_RX)) begin
                     check("rx_after_status", 64'(rx_allowed), 64'd1);
                     rx_allowed = 0;
                     check("rx_byte_available", 64'(rx_q.size() != 0), 64'd1);
                     if (rx_q.size() != 0) rd[7:0] = rx_q.pop_front();
                  end else begin
                     check("read_address", 64'(avm_address), 64'(A_STAT));
                  end
                  avm_readdata = rd;
               end else begin
                  check("write_address", 64'(avm_address), 64'(A_TX));
                  check("tx_after_status", 64'(tx_allowed), 64'd1);
                  tx_allowed = 0;
                  check("wdata_upper", 64'(avm_writedata[31:8]), 64'd0);
                  tx_log.push_back(avm_writedata[7:0]);
                  check("tx_byte_expected", 64'(exp_tx.size() != 0), 64'd1);
                  if (exp_tx.size() != 0) begin
                     exp_b = exp_tx.pop_front();
                     check("tx_byte", 64'(avm_writedata[7:0]), 64'(exp_b));
                  end
                  tx_in_block++;
                  if (tx_in_block == TXB) begin
                     tx_in_block = 0;
                     exp_block_count++;
                  end
               end
            end
         end else begin
            avm_waitrequest = 1'b0;
            pending         = 0;
         end
      end
   end

   // Modexp core model; holds a stale finished flag during the start cycle.
   initial begin
      logic [95:0] ops;
      int          lat;
      i_core_finished = 1'b0;
      i_core_result   = '0;
      ops = '0;
      forever begin
         @(negedge avm_clk);
         if (avm_rst) begin
            i_core_finished = 1'b0;
            continue;
         end
         if (o_core_start === 1'b1) begin
            n_starts++;
            check("busy_at_start", 64'(o_busy), 64'd1);
            check("ops_expected", 64'(exp_ops.size() != 0), 64'd1);
            if (exp_ops.size() != 0) ops = exp_ops.pop_front();
            check("core_a", 64'(o_core_a), 64'(ops[95:64]));
            check("core_d", 64'(o_core_d), 64'(ops[63:32]));
            check("core_n", 64'(o_core_n), 64'(ops[31:0]));
            i_core_finished = 1'b1;
            i_core_result   = 32'hDEADBEEF;
            @(negedge avm_clk);
            check("start_one_cycle", 64'(o_core_start), 64'd0);
            check("busy_during_core", 64'(o_busy), 64'd1);
            i_core_finished = 1'b0;
            lat = $urandom_range(6, 1);
            repeat (lat) @(negedge avm_clk);
            check("ops_stable_a", 64'(o_core_a), 64'(ops[95:64]));
            check("ops_stable_n", 64'(o_core_n), 64'(ops[31:0]));
            i_core_result   = modexp(o_core_a, o_core_d, o_core_n);
            i_core_finished = 1'b1;
            @(negedge avm_clk);
            i_core_finished = 1'b0;
            i_core_result   = $urandom;
            check("busy_after_core", 64'(o_busy), 64'd0);
         end
      end
   end

   task automatic tick();
      @(posedge avm_clk);
      #1;
   endtask

   task automatic wait_done(input string name, input int budget);
      int t;
      t = 0;
      while (exp_tx.size() != 0 && t < budget) begin
         tick();
         t++;
      end
      check(name, 64'(exp_tx.size()), 64'd0);
      repeat (4) tick();
   endtask

   task automatic check_reset();
      check("rst_address", 64'(avm_address), 64'd8);
      check("rst_read", 64'(avm_read), 64'd0);
      check("rst_write", 64'(avm_write), 64'd0);
      check("rst_block_count", 64'(o_block_count), 64'd0);
      check("rst_core_start", 64'(o_core_start), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
   endtask

   task automatic check_last3(input string name, input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0);
      int s;
      s = tx_log.size();
      check({name, "_len"}, 64'(s >= 3), 64'd1);
      if (s >= 3) begin
         check({name, "_b2"}, 64'(tx_log[s-3]), 64'(b2));
         check({name, "_b1"}, 64'(tx_log[s-2]), 64'(b1));
         check({name, "_b0"}, 64'(tx_log[s-1]), 64'(b0));
      end
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish, actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int t;
      avm_rst      = 1'b1;
      i_key_reload = 1'b0;

      // Model pins
      check("model_2_3_251", 64'(modexp(32'd2, 32'd3, 32'd251)), 64'd8);
      check("model_3_2_11", 64'(modexp(32'd3, 32'd2, 32'd11)), 64'd9);
      check("model_5_3_251", 64'(modexp(32'd5, 32'd3, 32'd251)), 64'd125);

      // T1 reset
      repeat (3) tick();
      check_reset();
      avm_rst = 1'b0;

      // T2 basic block, no stalls
      max_stall = 0;
      send_key(32'h0000_00FB, 32'h0000_0003);
      send_block(32'h0000_0002);
      wait_done("t2_done", 3000);
      check_last3("t2_tx", 8'h00, 8'h00, 8'h08);
      check("t2_tx_count", 64'(tx_log.size()), 64'd3);
      check("t2_starts", 64'(n_starts), 64'd1);
      check("t2_block_count", 64'(o_block_count), 64'd1);

      // T3 random stalls, key retained
      max_stall = 5;
      send_block(32'h0000_0002);
      wait_done("t3_done", 5000);
      check_last3("t3_tx", 8'h00, 8'h00, 8'h08);
      check("t3_block_count", 64'(o_block_count), 64'd2);

      // T4 status bits withheld
      max_stall = 1;
      send_block(32'h0000_0005);
      rx_deny = 20;
      tx_deny = 10;
      wait_done("t4_done", 5000);
      check_last3("t4_tx", 8'h00, 8'h00, 8'h7D);
      check("t4_rx_polls_used", 64'(rx_deny), 64'd0);
      check("t4_tx_polls_used", 64'(tx_deny), 64'd0);
      check("t4_block_count", 64'(o_block_count), 64'd3);

      // T5 key reload during a block; counter wraps 3 -> 0
      max_stall = 2;
      send_block(32'h0000_0007);
      i_key_reload = 1'b1;
      tick();
      i_key_reload = 1'b0;
      wait_done("t5a_done", 5000);
      check_last3("t5a_tx", 8'h00, 8'h00, 8'h5C);
      check("t5a_block_wrap", 64'(o_block_count), 64'd0);

      send_key(32'h0000_000B, 32'h0000_0002);
      send_block(32'h0000_0003);
      t = 0;
      while (rx_q.size() > 8 && t < 3000) begin
         tick();
         t++;
      end
      check("t5_in_key_phase", 64'(rx_q.size() > 4), 64'd1);
      i_key_reload = 1'b1;
      tick();
      i_key_reload = 1'b0;
      wait_done("t5b_done", 5000);
      check_last3("t5b_tx", 8'h00, 8'h00, 8'h09);
      check("t5b_block_count", 64'(o_block_count), 64'd1);

      send_key(32'h0000_00FB, 32'h0000_0003);
      send_block(32'h0000_0002);
      wait_done("t5c_done", 5000);
      check_last3("t5c_tx", 8'h00, 8'h00, 8'h08);
      check("t5c_block_count", 64'(o_block_count), 64'd2);

      // T6 reset during third TX byte
      send_block(32'h0000_0004);
      t = 0;
      while (tx_in_block < 2 && t < 5000) begin
         tick();
         t++;
      end
      check("t6_two_bytes_sent", 64'(tx_in_block), 64'd2);
      t = 0;
      while (avm_write !== 1'b1 && t < 2000) begin
         tick();
         t++;
      end
      check("t6_third_write_issued", 64'(avm_write), 64'd1);
      avm_rst = 1'b1;
      rx_q.delete();
      exp_tx.delete();
      exp_ops.delete();
      tx_in_block     = 0;
      exp_block_count = '0;
      repeat (2) tick();
      check_reset();
      avm_rst = 1'b0;
      send_key(32'h0000_00FB, 32'h0000_0003);
      send_block(32'h0000_0002);
      wait_done("t6_done", 5000);
      check_last3("t6_tx", 8'h00, 8'h00, 8'h08);
      check("t6_block_count", 64'(o_block_count), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
